// File: rtl/dbus_ctrl_pkg.sv
// Shared types for the memory-stage data bus controller: bus request/response
// structs, access size encoding and controller state encoding.
package dbus_ctrl_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef logic [1:0] dbus_ctrl_state_t;

  localparam dbus_ctrl_state_t ST_IDLE = 2'd0;
  localparam dbus_ctrl_state_t ST_WAIT = 2'd1;
  localparam dbus_ctrl_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/dbus_ctrl_if.sv
// Data bus channel: request toward memory, response back to the controller.
interface dbus_ctrl_if;
  import dbus_ctrl_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_ctrl_align.sv
// Combinational natural-alignment check of an access; shared with exception logic.
module mem_align_check
  import dbus_ctrl_pkg::*;
(
  input  logic [2:0] addr_lo,
  input  msize_t     size,
  output logic       misaligned
);

  always_comb begin
    misaligned = 1'b0;
    case (size)
      MSIZE1:  misaligned = 1'b0;
      MSIZE2:  misaligned = addr_lo[0];
      MSIZE4:  misaligned = |addr_lo[1:0];
      MSIZE8:  misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/dbus_ctrl.sv
// Memory-stage data bus sequencer: issues the request, holds it until data_ok,
// stalls the pipeline while outstanding, traps misalignment and counts activity.
module dbus_ctrl
  import dbus_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  dbus_req_t         req_in,
  input  logic              hold,
  dbus_ctrl_if.master       dbus,
  output logic [63:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic [CNT_W-1:0]  n_access,
  output logic [CNT_W-1:0]  n_stall
);

  dbus_ctrl_state_t state_q, state_d;
  dbus_req_t        req_q, req_d;
  logic [63:0]      data_q, data_d;
  logic [CNT_W-1:0] n_access_q, n_access_d;
  logic [CNT_W-1:0] n_stall_q, n_stall_d;
  logic             mis_raw;
  logic             acc_done;

  mem_align_check u_align (
    .addr_lo    (req_in.addr[2:0]),
    .size       (req_in.size),
    .misaligned (mis_raw)
  );

  assign misalign = (state_q == ST_IDLE) && req_in.valid && mis_raw;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    dbus.dreq = '0;
    rdata     = dbus.dresp.data;
    stall     = 1'b0;
    acc_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_in.valid && !mis_raw) begin
          dbus.dreq = req_in;
          req_d     = req_in;
          if (dbus.dresp.data_ok) begin
            acc_done = 1'b1;
            if (hold) begin
              data_d  = dbus.dresp.data;
              state_d = ST_DONE;
            end
          end else begin
            stall   = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Replay the latched request so the bus sees stable fields whatever req_in does.
        dbus.dreq       = req_q;
        dbus.dreq.valid = 1'b1;
        if (dbus.dresp.data_ok) begin
          acc_done = 1'b1;
          if (hold) begin
            data_d  = dbus.dresp.data;
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          stall = 1'b1;
        end
      end
      ST_DONE: begin
        rdata = data_q;
        if (!hold) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    n_access_d = n_access_q + {{(CNT_W-1){1'b0}}, acc_done};
    n_stall_d  = n_stall_q + {{(CNT_W-1){1'b0}}, stall};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      data_q     <= '0;
      n_access_q <= '0;
      n_stall_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_q     <= data_d;
      n_access_q <= n_access_d;
      n_stall_q  <= n_stall_d;
    end
  end

  assign n_access = n_access_q;
  assign n_stall  = n_stall_q;

endmodule

// File: doc/dbus_ctrl.md
# dbus_ctrl

Sequencing controller between the memory stage and the data bus. It takes the memory stage's combinational `dbus_req_t`, issues it on `dreq`, and holds every field stable until `data_ok`. It captures the response and stalls the pipeline while the access is outstanding. It also traps misaligned accesses before they reach the bus and counts accesses and stall cycles for performance reporting.

## Interface
Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `req_in`  in  `dbus_req_t`: request from the memory stage. `valid` is already gated by bubble.
- `hold`  in  1: a downstream or other hazard prevents the M→W register from advancing this cycle.
- `dreq`  out  `dbus_req_t`: request to the data bus.
- `dresp`  in  `dbus_resp_t`: bus response (`addr_ok`, `data_ok`, `data`).
- `rdata`  out  64: raw 64-bit load data for the memory stage's extraction logic.
- `stall`  out  1: the memory access has not completed, so the pipeline must freeze.
- `misalign`  out  1: `req_in` addr is not aligned to its size; no bus request is issued.
- `n_access`  out  `CNT_W`: completed bus accesses.
- `n_stall`  out  `CNT_W`: cycles with `stall`=1.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - Misaligned request (`req_in.valid` and addr[2:0] not aligned to `size`): `misalign`=1, `dreq.valid`=0, `stall`=0, state unchanged.
  - Aligned valid request: drive `dreq`=`req_in` combinationally and latch `req_in` into `req_q`.
  - `data_ok` in the same cycle with `hold`=0: complete. `rdata`=`dresp.data`, `stall`=0, stay in IDLE.
  - `data_ok` in the same cycle with `hold`=1: capture data into `data_q`, go to DONE, `stall`=0.
  - No `data_ok`: `stall`=1, go to WAIT.
- WAIT:
  - Drive `dreq`=`req_q` (`valid`=1), ignoring `req_in`. `stall`=1 until `data_ok`.
  - On `data_ok`: `rdata`=`dresp.data`, `stall`=0. Go to DONE with `data_q` captured if `hold`=1, else go to IDLE.
- DONE:
  - Instruction finished, pipeline still frozen. `dreq.valid`=0 so there is no reissue.
  - `rdata`=`data_q`, `stall`=0. Go to IDLE when `hold`=0.
- `addr_ok` is ignored. Completion is defined by `data_ok` only, and `addr_ok`/`data_ok` may coincide.
- Alignment rules:
  - MSIZE1: always aligned.
  - MSIZE2: addr[0]=0.
  - MSIZE4: addr[1:0]=0.
  - MSIZE8: addr[2:0]=0.
- Counters:
  - `n_access` increments once per `data_ok` while a request is driven.
  - `n_stall` increments on each cycle with `stall`=1.
  - Both wrap modulo 2^`CNT_W`.
- Stores behave the same as loads. `rdata` is don't-care for stores but is still driven from the bus or `data_q`.

## Timing
- Reset: state=IDLE. `req_q`, `data_q`, `n_access` and `n_stall` are all 0. With `req_in.valid`=0, outputs are `dreq.valid`=0, `stall`=0 and `misalign`=0.
- Zero-wait bus (`data_ok` in the issue cycle): 0 stall cycles.
- Latency `k` (`data_ok` k cycles after issue): exactly k stall cycles.
- `dreq` fields are stable from the issue cycle through the `data_ok` cycle inclusive.
- `req_in` changing while in WAIT has no effect on `dreq`.
- `stall` is combinational from `dresp.data_ok` and the state. There is no registered delay on completion.
- `reset` during WAIT: the next cycle is IDLE with `dreq.valid`=0, and the outstanding response is discarded (the whole system resets).
- `hold` and `data_ok` asserted together in WAIT: go to DONE. The data must not be lost.

## Structure
- Add `dbus_ctrl_state_t` (IDLE/WAIT/DONE) to the `pipes` package.
- `dbus_req_t`, `dbus_resp_t` and `msize_t` already live in `common`.
- One sub-module, `mem_align_check`: combinational `(addr[2:0], msize) → misaligned`. It is reused later by exception logic.
- Counters stay inline.

## Test plan
- Zero-wait load: addr 0x80000008, MSIZE8, `data_ok` in the same cycle, `hold`=0 → `stall` never 1, `rdata`=bus data, `n_access`=1, state stays IDLE.
- 3-cycle latency store: addr 0x80000010, strobe 0xFF. `req_in` is changed to addr 0x0 during the wait → `dreq` stays at 0x80000010 with valid for 4 cycles, `stall`=1 for 3 cycles, `n_stall`=3.
- Completion under hold: `data_ok` in WAIT with `hold`=1 for 2 more cycles → DONE, `dreq.valid`=0, `rdata`=0xDEADBEEF_CAFEF00D held stable, then IDLE when `hold` drops. Exactly one bus transaction occurs.
- Misaligned: MSIZE4 at addr 0x80000002 → `misalign`=1, `dreq.valid`=0, `stall`=0, counters unchanged. MSIZE2 at 0x...6 → aligned and issued.
- Reset in WAIT: assert `reset` 1 cycle after issue → next cycle IDLE, `dreq.valid`=0, counters 0. A late `data_ok` is ignored.
- Counter wrap with `CNT_W`=4: 17 zero-wait accesses → `n_access`=1.
